// File: rtl/stereo_lpf_sched_if.sv
// Sample handshake between the stereo scheduler and the shared single-channel filter core.
// The scheduler drives the master side; the filter core sits on the slave side.
interface stereo_lpf_sched_if #(
  parameter int DATA_W = 18
);
  logic              core_in_rdy;
  logic [DATA_W-1:0] core_in;
  logic              core_ch;
  logic              core_out_rdy;
  logic [DATA_W-1:0] core_out;

  modport master (
    output core_in_rdy,
    output core_in,
    output core_ch,
    input  core_out_rdy,
    input  core_out
  );

  modport slave (
    input  core_in_rdy,
    input  core_in,
    input  core_ch,
    output core_out_rdy,
    output core_out
  );
endinterface

// File: rtl/stereo_lpf_sched.sv
// Time-multiplexes one IIR low-pass core between the L and R sample streams (one pending sample per channel).
// Define STEREO_SCHED_OVR_CNT_EN to build the saturating per-channel overrun counters; otherwise they read 0.
module stereo_lpf_sched #(
  parameter int DATA_W  = 18,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                smpl_in_rdy_l,
  input  logic [DATA_W-1:0]   smpl_in_l,
  input  logic                smpl_in_rdy_r,
  input  logic [DATA_W-1:0]   smpl_in_r,
  stereo_lpf_sched_if.master  core,
  output logic                smpl_out_rdy_l,
  output logic [DATA_W-1:0]   smpl_out_l,
  output logic                smpl_out_rdy_r,
  output logic [DATA_W-1:0]   smpl_out_r,
  output logic                busy,
  output logic                err_overrun,
  output logic                err_timeout,
  output logic [7:0]          ovr_cnt_l,
  output logic [7:0]          ovr_cnt_r
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_last_srv;
  logic [DATA_W-1:0] r_core_in;
  logic              r_core_ch;
  logic [TO_W-1:0]   r_timer;
  logic              r_err_overrun;

  logic [1:0]        w_strb;
  logic [DATA_W-1:0] w_din [2];
  logic [1:0]        w_pend;
  logic [DATA_W-1:0] w_hold [2];
  logic [1:0]        w_out_rdy;
  logic [DATA_W-1:0] w_out [2];
  logic [1:0]        w_ovr;
  logic [7:0]        w_ovr_cnt [2];

  logic              w_sel_vld;
  logic              w_sel;
  logic              w_done;
  logic              w_timeout;
  logic              w_issue;
  logic              w_busy;

  // Channel index 0 is left, 1 is right throughout.
  assign w_strb  = {smpl_in_rdy_r, smpl_in_rdy_l};
  assign w_din[0] = smpl_in_l;
  assign w_din[1] = smpl_in_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sel_vld    = 1'b0;
    w_sel        = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_issue      = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (|w_pend) begin
          w_sel_vld    = 1'b1;
          w_sel        = (&w_pend) ? ~r_last_srv : w_pend[1];
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (core.core_out_rdy) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_timer == TO_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_srv    <= 1'b1;
      r_core_in     <= '0;
      r_core_ch     <= 1'b0;
      r_timer       <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      r_err_overrun <= |w_ovr;
      if (w_sel_vld) begin
        r_core_in  <= w_hold[w_sel];
        r_core_ch  <= w_sel;
        r_last_srv <= w_sel;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT) begin
        r_timer <= r_timer + TO_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic CH = 1'(gi);

      logic              r_pend;
      logic [DATA_W-1:0] r_hold;
      logic              r_out_rdy;
      logic [DATA_W-1:0] r_out;
      logic              w_take;
      logic              w_land;

      assign w_take    = w_sel_vld && (w_sel == CH);
      assign w_land    = w_done && (r_core_ch == CH);
      // Taking the old sample in the same cycle as a new strobe is not an overrun.
      assign w_ovr[gi] = w_strb[gi] && r_pend && !w_take;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_pend    <= 1'b0;
          r_hold    <= '0;
          r_out_rdy <= 1'b0;
          r_out     <= '0;
        end else begin
          if (w_strb[gi]) begin
            r_hold <= w_din[gi];
            r_pend <= 1'b1;
          end else if (w_take) begin
            r_pend <= 1'b0;
          end
          r_out_rdy <= w_land;
          if (w_land) begin
            r_out <= core.core_out;
          end
        end
      end

      assign w_pend[gi]    = r_pend;
      assign w_hold[gi]    = r_hold;
      assign w_out_rdy[gi] = r_out_rdy;
      assign w_out[gi]     = r_out;

`ifdef STEREO_SCHED_OVR_CNT_EN
      logic [7:0] r_ovr_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_ovr_cnt <= 8'd0;
        end else if (w_ovr[gi] && (r_ovr_cnt != 8'hFF)) begin
          r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
      end

      assign w_ovr_cnt[gi] = r_ovr_cnt;
`else
      assign w_ovr_cnt[gi] = 8'd0;
`endif
    end
  endgenerate

  assign core.core_in_rdy = w_issue;
  assign core.core_in     = r_core_in;
  assign core.core_ch     = r_core_ch;

  assign smpl_out_rdy_l = w_out_rdy[0];
  assign smpl_out_l     = w_out[0];
  assign smpl_out_rdy_r = w_out_rdy[1];
  assign smpl_out_r     = w_out[1];

  assign busy        = w_busy;
  assign err_overrun = r_err_overrun;
  assign err_timeout = w_timeout;
  assign ovr_cnt_l   = w_ovr_cnt[0];
  assign ovr_cnt_r   = w_ovr_cnt[1];

endmodule

// File: tb/tb_stereo_lpf_sched.sv
// Random plus directed stimulus for stereo_lpf_sched, checked every cycle against a timestamp-based model.
// Expected ovr_cnt_* follows STEREO_SCHED_OVR_CNT_EN the same way the design does.
module tb_stereo_lpf_sched;
  localparam int DATA_W    = 18;
  localparam int TIMEOUT   = 255;
  localparam int TO_W      = 8;
  localparam int NCYC      = 6000;
  localparam int RND_START = 900;
  localparam int RND_END   = NCYC - 300;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              smpl_in_rdy_l = 1'b0;
  logic [DATA_W-1:0] smpl_in_l = '0;
  logic              smpl_in_rdy_r = 1'b0;
  logic [DATA_W-1:0] smpl_in_r = '0;
  logic              smpl_out_rdy_l;
  logic [DATA_W-1:0] smpl_out_l;
  logic              smpl_out_rdy_r;
  logic [DATA_W-1:0] smpl_out_r;
  logic              busy;
  logic              err_overrun;
  logic              err_timeout;
  logic [7:0]        ovr_cnt_l;
  logic [7:0]        ovr_cnt_r;

  stereo_lpf_sched_if #(.DATA_W(DATA_W)) core_bus ();

  stereo_lpf_sched #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .smpl_in_rdy_l  (smpl_in_rdy_l),
    .smpl_in_l      (smpl_in_l),
    .smpl_in_rdy_r  (smpl_in_rdy_r),
    .smpl_in_r      (smpl_in_r),
    .core           (core_bus),
    .smpl_out_rdy_l (smpl_out_rdy_l),
    .smpl_out_l     (smpl_out_l),
    .smpl_out_rdy_r (smpl_out_rdy_r),
    .smpl_out_r     (smpl_out_r),
    .busy           (busy),
    .err_overrun    (err_overrun),
    .err_timeout    (err_timeout),
    .ovr_cnt_l      (ovr_cnt_l),
    .ovr_cnt_r      (ovr_cnt_r)
  );

  always #5 clk = ~clk;

  // Stimulus plan, one entry per cycle; kfix: 0 random latency, -1 core never answers, >0 fixed latency.
  bit                plan_rst [NCYC];
  bit                plan_sl  [NCYC];
  bit                plan_sr  [NCYC];
  logic [DATA_W-1:0] plan_vl  [NCYC];
  logic [DATA_W-1:0] plan_vr  [NCYC];
  int                kfix     [NCYC];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Bench-side core: answers resp_at with resp_val.
  int                resp_at = -1;
  logic [DATA_W-1:0] resp_val = '0;

  // Reference model: pending slots, timestamps of the in-flight job, held outputs.
  bit                m_pend [2];
  logic [DATA_W-1:0] m_val  [2];
  logic [DATA_W-1:0] m_out  [2];
  int                m_cnt  [2];
  bit                m_inc  [2];
  logic [DATA_W-1:0] m_cin;
  bit                m_cch;
  bit                m_last;
  int                m_issue_at;
  int                m_free;
  bit                n_ovr;
  bit                n_ordy [2];
  logic [DATA_W-1:0] n_oval;

  bit                e_ovr;
  bit                e_ordy [2];
  bit                e_rdy;
  bit                e_busy;
  bit                e_to;
  logic [DATA_W-1:0] e_cin;
  bit                e_cch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_pend[ch] = 1'b0;
      m_val[ch]  = '0;
      m_out[ch]  = '0;
      m_cnt[ch]  = 0;
      m_inc[ch]  = 1'b0;
      n_ordy[ch] = 1'b0;
      e_ordy[ch] = 1'b0;
    end
    m_cin      = '0;
    m_cch      = 1'b0;
    m_last     = 1'b1;
    m_issue_at = -1;
    m_free     = 0;
    n_ovr      = 1'b0;
    n_oval     = '0;
    e_ovr      = 1'b0;
    e_rdy      = 1'b0;
    e_busy     = 1'b0;
    e_to       = 1'b0;
    e_cin      = '0;
    e_cch      = 1'b0;
  endtask

  task automatic model_step(input int c, input bit sl, input logic [DATA_W-1:0] vl,
                            input bit sr, input logic [DATA_W-1:0] vr,
                            input bit cordy, input logic [DATA_W-1:0] cout);
    bit                stb [2];
    logic [DATA_W-1:0] val [2];
    bit                sel;
    bit                ovr_any;
    stb[0] = sl; stb[1] = sr;
    val[0] = vl; val[1] = vr;

    // Effects registered at the end of the previous cycle become visible now.
    e_ovr = n_ovr;
    n_ovr = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      e_ordy[ch] = n_ordy[ch];
      if (n_ordy[ch]) m_out[ch] = n_oval;
      n_ordy[ch] = 1'b0;
      if (m_inc[ch] && m_cnt[ch] < 255) m_cnt[ch]++;
      m_inc[ch] = 1'b0;
    end
    e_cin  = m_cin;
    e_cch  = m_cch;
    e_rdy  = (c == m_issue_at);
    e_busy = (m_issue_at >= 0) && (c >= m_issue_at);
    e_to   = 1'b0;

    if (m_issue_at >= 0) begin
      if (c > m_issue_at) begin
        if (cordy) begin
          n_ordy[m_cch] = 1'b1;
          n_oval        = cout;
          m_issue_at    = -1;
          m_free        = c + 1;
        end else if (c == m_issue_at + TIMEOUT) begin
          e_to       = 1'b1;
          m_issue_at = -1;
          m_free     = c + 1;
        end
      end
    end else if (c >= m_free && (m_pend[0] || m_pend[1])) begin
      sel        = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
      m_issue_at = c + 1;
      m_cin      = m_val[sel];
      m_cch      = sel;
      m_last     = sel;
      m_pend[sel] = 1'b0;
    end

    ovr_any = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      if (stb[ch]) begin
        if (m_pend[ch]) begin
          ovr_any   = 1'b1;
          m_inc[ch] = 1'b1;
        end
        m_val[ch]  = val[ch];
        m_pend[ch] = 1'b1;
      end
    end
    n_ovr = ovr_any;
  endtask

  task automatic build_plan();
    for (int c = 0; c < NCYC; c++) begin
      plan_rst[c] = (c < 3);
      plan_sl[c]  = 1'b0;
      plan_sr[c]  = 1'b0;
      plan_vl[c]  = DATA_W'($urandom);
      plan_vr[c]  = DATA_W'($urandom);
      kfix[c]     = 0;
    end
    // Single L, core echo after 4 cycles.
    plan_sl[5] = 1'b1; plan_vl[5] = 18'h00123; kfix[7] = 4;
    // Tie after reset: L first, then R.
    plan_sl[20] = 1'b1; plan_vl[20] = 18'd5;
    plan_sr[20] = 1'b1; plan_vr[20] = DATA_W'(-5);
    kfix[22] = 1; kfix[25] = 1;
    // Tie right after an L service: R first.
    plan_sl[40] = 1'b1; kfix[42] = 2;
    plan_sl[44] = 1'b1; plan_sr[44] = 1'b1;
    // L overrun while the core works on R.
    plan_sr[60] = 1'b1; kfix[62] = 8;
    plan_sl[63] = 1'b1; plan_vl[63] = 18'd10;
    plan_sl[65] = 1'b1; plan_vl[65] = 18'd20;
    // Core never answers; pending R follows the timeout.
    plan_sl[100] = 1'b1; kfix[102] = -1;
    plan_sr[110] = 1'b1;
    // Strobe coincident with selection of the same channel.
    plan_sl[420] = 1'b1; plan_vl[420] = 18'h0AAAA;
    plan_sl[421] = 1'b1; plan_vl[421] = 18'h15555;
    kfix[422] = 2;
    // Reset during WAIT; the late core strobe must be ignored.
    plan_sl[450] = 1'b1; kfix[452] = 6;
    plan_rst[455] = 1'b1; plan_rst[456] = 1'b1;
    // Answer on the very last cycle before timeout.
    plan_sl[600] = 1'b1; kfix[602] = TIMEOUT;
    for (int c = RND_START; c < RND_END; c++) begin
      kfix[c] = ($urandom_range(0, 39) == 0) ? -1 : 0;
      if (plan_rst[c]) continue;
      if ($urandom_range(0, 1499) == 0) begin
        plan_rst[c]     = 1'b1;
        plan_rst[c + 1] = 1'b1;
      end else begin
        plan_sl[c] = ($urandom_range(0, 7) == 0);
        plan_sr[c] = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  initial begin
    int k;
    core_bus.core_out_rdy = 1'b0;
    core_bus.core_out     = '0;
    build_plan();
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      reset_n       = !plan_rst[c];
      smpl_in_rdy_l = plan_sl[c];
      smpl_in_l     = plan_vl[c];
      smpl_in_rdy_r = plan_sr[c];
      smpl_in_r     = plan_vr[c];
      core_bus.core_out_rdy = (c == resp_at);
      core_bus.core_out     = (c == resp_at) ? resp_val : DATA_W'($urandom);
      if (plan_rst[c]) begin
        model_reset();
      end else begin
        model_step(c, plan_sl[c], plan_vl[c], plan_sr[c], plan_vr[c],
                   core_bus.core_out_rdy, core_bus.core_out);
      end

      @(negedge clk);
      check_eq("core_in_rdy", 32'(core_bus.core_in_rdy), 32'(e_rdy));
      check_eq("core_in", 32'(core_bus.core_in), 32'(e_cin));
      check_eq("core_ch", 32'(core_bus.core_ch), 32'(e_cch));
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("err_timeout", 32'(err_timeout), 32'(e_to));
      check_eq("err_overrun", 32'(err_overrun), 32'(e_ovr));
      check_eq("smpl_out_rdy_l", 32'(smpl_out_rdy_l), 32'(e_ordy[0]));
      check_eq("smpl_out_rdy_r", 32'(smpl_out_rdy_r), 32'(e_ordy[1]));
      check_eq("smpl_out_l", 32'(smpl_out_l), 32'(m_out[0]));
      check_eq("smpl_out_r", 32'(smpl_out_r), 32'(m_out[1]));
`ifdef STEREO_SCHED_OVR_CNT_EN
      check_eq("ovr_cnt_l", 32'(ovr_cnt_l), 32'(m_cnt[0]));
      check_eq("ovr_cnt_r", 32'(ovr_cnt_r), 32'(m_cnt[1]));
`else
      check_eq("ovr_cnt_l", 32'(ovr_cnt_l), 32'd0);
      check_eq("ovr_cnt_r", 32'(ovr_cnt_r), 32'd0);
`endif

      if (core_bus.core_in_rdy) begin
        k = kfix[c];
        if (k == 0) k = $urandom_range(1, 12);
        if (k < 0) begin
          resp_at = -1;
        end else begin
          resp_at  = c + k;
          resp_val = core_bus.core_in + (core_bus.core_ch ? DATA_W'(1000) : DATA_W'(0));
        end
        $display("ISSUE cyc=%0d ch=%0d val=%0h k=%0d", c, core_bus.core_ch, core_bus.core_in, k);
      end
      if (smpl_out_rdy_l) $display("OUT   cyc=%0d ch=0 val=%0h", c, smpl_out_l);
      if (smpl_out_rdy_r) $display("OUT   cyc=%0d ch=1 val=%0h", c, smpl_out_r);
      if (err_timeout)    $display("TMO   cyc=%0d", c);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
